// File: rtl/scarv_cop_insn_issue_pkg.sv
// Shared types for the co-processor issue stage: status codes, FSM encoding,
// buffered instruction entries and latched responses.
package scarv_cop_insn_issue_pkg;

  localparam logic [2:0] SCARV_COP_INSN_SUCCESS = 3'b000;
  localparam logic [2:0] SCARV_COP_INSN_ILLEGAL = 3'b001;
  localparam logic [2:0] SCARV_COP_INSN_BAD_INS = 3'b010;
  localparam logic [2:0] SCARV_COP_INSN_BAD_LAD = 3'b011;
  localparam logic [2:0] SCARV_COP_INSN_BAD_SAD = 3'b100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } issue_state_t;

  typedef struct packed {
    logic [31:0] enc;
    logic [31:0] rs1;
  } insn_ent_t;

  typedef struct packed {
    logic [2:0]  status;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] wdata;
  } insn_rsp_t;

endpackage

// File: rtl/scarv_cop_insn_issue_if.sv
// CPU <-> co-processor instruction request / response bus.
interface scarv_cop_insn_issue_if;
  logic        cpu_insn_req;
  logic        cpu_insn_ack;
  logic [31:0] cpu_insn_enc;
  logic [31:0] cpu_rs1;
  logic        cop_rsp_valid;
  logic        cop_rsp_ready;
  logic [2:0]  cop_rsp_status;
  logic        cop_rsp_wen;
  logic [4:0]  cop_rsp_rd;
  logic [31:0] cop_rsp_wdata;

  modport master (
    output cpu_insn_req, cpu_insn_enc, cpu_rs1, cop_rsp_ready,
    input  cpu_insn_ack, cop_rsp_valid, cop_rsp_status, cop_rsp_wen,
           cop_rsp_rd, cop_rsp_wdata
  );

  modport slave (
    input  cpu_insn_req, cpu_insn_enc, cpu_rs1, cop_rsp_ready,
    output cpu_insn_ack, cop_rsp_valid, cop_rsp_status, cop_rsp_wen,
           cop_rsp_rd, cop_rsp_wdata
  );
endinterface

// File: rtl/scarv_cop_insn_fifo.sv
// Synchronous instruction buffer; pointers carry one extra wrap bit so
// full and empty are distinguishable without a counter.
module scarv_cop_insn_fifo
  import scarv_cop_insn_issue_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int FIFO_AW    = 1
) (
  input  logic      g_clk,
  input  logic      g_reset,
  input  logic      push,
  input  insn_ent_t push_data,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output insn_ent_t head
);

  insn_ent_t          mem [FIFO_DEPTH];
  logic [FIFO_AW:0]   wptr, rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                 (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  // Head reads as zero when empty so the decoder sees a quiet bus.
  assign head  = empty ? '0 : mem[rptr[FIFO_AW-1:0]];

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge g_clk) begin
    if (push) mem[wptr[FIFO_AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/scarv_cop_insn_issue.sv
// Issue stage: buffers CPU instructions, steps the FIFO head through
// decode/execute one at a time and returns the CPU response.
module scarv_cop_insn_issue
  import scarv_cop_insn_issue_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int FIFO_AW    = 1
) (
  input  logic                   g_clk,
  input  logic                   g_reset,
  scarv_cop_insn_issue_if.slave  cpu,
  output logic [31:0]            id_encoded,
  input  logic                   id_exception,
  input  logic [4:0]             id_rd,
  output logic                   ex_valid,
  output logic [31:0]            ex_rs1,
  input  logic                   ex_ready,
  input  logic [2:0]             ex_status,
  input  logic                   ex_wen,
  input  logic [31:0]            ex_wdata
);

  issue_state_t state, state_nxt;
  insn_rsp_t    rsp_q, rsp_nxt;
  insn_ent_t    push_data, head;
  logic         full, empty, push, pop, in_resp;

  // Ack depends only on registered occupancy; no combinational path from pop.
  assign cpu.cpu_insn_ack = !full;
  assign push             = cpu.cpu_insn_req && !full;
  assign push_data.enc    = cpu.cpu_insn_enc;
  assign push_data.rs1    = cpu.cpu_rs1;

  scarv_cop_insn_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .FIFO_AW    (FIFO_AW)
  ) u_fifo (
    .g_clk     (g_clk),
    .g_reset   (g_reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  assign id_encoded = head.enc;
  assign ex_rs1     = head.rs1;

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state <= IDLE;
      rsp_q <= '0;
    end else begin
      state <= state_nxt;
      rsp_q <= rsp_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rsp_nxt   = rsp_q;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          rsp_nxt.rd = id_rd;
          if (id_exception) begin
            rsp_nxt.status = SCARV_COP_INSN_ILLEGAL;
            rsp_nxt.wen    = 1'b0;
            rsp_nxt.wdata  = '0;
            state_nxt      = RESP;
          end else begin
            state_nxt = EXEC;
          end
        end
      end
      EXEC: begin
        if (ex_ready) begin
          rsp_nxt.status = ex_status;
          rsp_nxt.wen    = ex_wen;
          rsp_nxt.wdata  = ex_wen ? ex_wdata : '0;
          state_nxt      = RESP;
        end
      end
      RESP: begin
        if (cpu.cop_rsp_ready) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ex_valid           = (state == EXEC);
  assign in_resp            = (state == RESP);
  assign cpu.cop_rsp_valid  = in_resp;
  assign cpu.cop_rsp_status = in_resp ? rsp_q.status : '0;
  assign cpu.cop_rsp_wen    = in_resp ? rsp_q.wen    : 1'b0;
  assign cpu.cop_rsp_rd     = in_resp ? rsp_q.rd     : '0;
  assign cpu.cop_rsp_wdata  = in_resp ? rsp_q.wdata  : '0;

endmodule

// File: tb/tb_scarv_cop_insn_issue.sv
// Directed bench for the issue stage: inputs change and outputs are sampled
// on the falling edge, so each negedge observes the state after a rising edge.
module tb_scarv_cop_insn_issue;

  logic        g_clk, g_reset;
  logic [31:0] id_encoded, ex_rs1, ex_wdata, ex_wdata_r;
  logic        id_exception, ex_valid, ex_ready, ex_wen, echo;
  logic [4:0]  id_rd;
  logic [2:0]  ex_status;
  int          nchk, nerr, sent, rcnt, hits;

  scarv_cop_insn_issue_if bus ();

  scarv_cop_insn_issue #(.FIFO_DEPTH(2), .FIFO_AW(1)) dut (
    .g_clk        (g_clk),
    .g_reset      (g_reset),
    .cpu          (bus),
    .id_encoded   (id_encoded),
    .id_exception (id_exception),
    .id_rd        (id_rd),
    .ex_valid     (ex_valid),
    .ex_rs1       (ex_rs1),
    .ex_ready     (ex_ready),
    .ex_status    (ex_status),
    .ex_wen       (ex_wen),
    .ex_wdata     (ex_wdata)
  );

  // Decoder model: all-zero encoding is illegal, rd taken from bits 15:11.
  assign id_rd        = id_encoded[15:11];
  assign id_exception = (id_encoded == 32'h0);
  assign ex_wdata     = echo ? (ex_rs1 ^ 32'hFFFF_0000) : ex_wdata_r;

  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge g_clk);
  endtask

  function automatic logic [31:0] enc_of(input int i);
    enc_of = {16'h0, 5'(i + 3), 11'h033};
  endfunction

  function automatic logic [31:0] rs1_of(input int i);
    rs1_of = 32'h1000_0000 + i * 32'h0101_0101;
  endfunction

  initial begin
    nchk = 0; nerr = 0;
    g_reset = 1'b1; echo = 1'b0;
    bus.cpu_insn_req = 0; bus.cpu_insn_enc = 0; bus.cpu_rs1 = 0; bus.cop_rsp_ready = 0;
    ex_ready = 0; ex_status = 0; ex_wen = 0; ex_wdata_r = 0;
    nxt(); nxt();
    chk("rst_ack", bus.cpu_insn_ack, 1);
    chk("rst_valid", bus.cop_rsp_valid, 0);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_id_enc", id_encoded, 0);
    chk("rst_ex_rs1", ex_rs1, 0);
    chk("rst_status", bus.cop_rsp_status, 0);
    chk("rst_wdata", bus.cop_rsp_wdata, 0);
    g_reset = 1'b0;
    nxt();

    // Legal instruction, minimum latency
    ex_ready = 1; ex_status = 3'b000; ex_wen = 1; ex_wdata_r = 32'h1234_5678;
    bus.cop_rsp_ready = 1;
    bus.cpu_insn_req = 1; bus.cpu_insn_enc = 32'h0000_102B; bus.cpu_rs1 = 32'hDEAD_BEEF;
    nxt();
    bus.cpu_insn_req = 0;
    chk("leg_c1_id_enc", id_encoded, 32'h0000_102B);
    chk("leg_c1_ex_valid", ex_valid, 0);
    chk("leg_c1_valid", bus.cop_rsp_valid, 0);
    nxt();
    chk("leg_c2_ex_valid", ex_valid, 1);
    chk("leg_c2_ex_rs1", ex_rs1, 32'hDEAD_BEEF);
    chk("leg_c2_valid", bus.cop_rsp_valid, 0);
    nxt();
    chk("leg_c3_valid", bus.cop_rsp_valid, 1);
    chk("leg_c3_rd", bus.cop_rsp_rd, 2);
    chk("leg_c3_wdata", bus.cop_rsp_wdata, 32'h1234_5678);
    chk("leg_c3_status", bus.cop_rsp_status, 3'b000);
    chk("leg_c3_wen", bus.cop_rsp_wen, 1);
    chk("leg_c3_ex_valid", ex_valid, 0);
    nxt();
    chk("leg_c4_valid", bus.cop_rsp_valid, 0);
    chk("leg_c4_id_enc", id_encoded, 0);

    // Illegal instruction bypasses execute
    ex_ready = 0;
    bus.cpu_insn_req = 1; bus.cpu_insn_enc = 32'h0; bus.cpu_rs1 = 32'hCAFE_0001;
    nxt();
    bus.cpu_insn_req = 0;
    chk("ill_c1_ex_valid", ex_valid, 0);
    chk("ill_c1_valid", bus.cop_rsp_valid, 0);
    nxt();
    chk("ill_c2_valid", bus.cop_rsp_valid, 1);
    chk("ill_c2_status", bus.cop_rsp_status, 3'b001);
    chk("ill_c2_wen", bus.cop_rsp_wen, 0);
    chk("ill_c2_wdata", bus.cop_rsp_wdata, 0);
    chk("ill_c2_ex_valid", ex_valid, 0);
    nxt();
    chk("ill_c3_valid", bus.cop_rsp_valid, 0);
    chk("ill_c3_ex_valid", ex_valid, 0);

    // Backpressure: response held, FIFO fills, third request refused
    bus.cop_rsp_ready = 0;
    ex_ready = 1; ex_status = 3'b010; ex_wen = 1; ex_wdata_r = 32'hAAAA_5555;
    bus.cpu_insn_req = 1; bus.cpu_insn_enc = 32'h0000_F000; bus.cpu_rs1 = 32'h1;
    nxt();
    chk("bp_ack_one", bus.cpu_insn_ack, 1);
    bus.cpu_insn_enc = 32'h0000_0800; bus.cpu_rs1 = 32'h2;
    nxt();
    chk("bp_ack_full", bus.cpu_insn_ack, 0);
    bus.cpu_insn_enc = 32'h0000_4800; bus.cpu_rs1 = 32'h3;
    nxt();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", bus.cop_rsp_valid, 1);
      chk("bp_status", bus.cop_rsp_status, 3'b010);
      chk("bp_rd", bus.cop_rsp_rd, 30);
      chk("bp_wdata", bus.cop_rsp_wdata, 32'hAAAA_5555);
      chk("bp_ack_held", bus.cpu_insn_ack, 0);
      ex_wdata_r = 32'hBBBB_BBBB;
      if (i == 4) bus.cop_rsp_ready = 1;
      nxt();
    end
    chk("bp_ack_back", bus.cpu_insn_ack, 1);
    chk("bp_valid_off", bus.cop_rsp_valid, 0);
    chk("bp_head_b", id_encoded, 32'h0000_0800);
    bus.cpu_insn_req = 0;
    for (int n = 0; n < 10 && !bus.cop_rsp_valid; n++) nxt();
    chk("bp_b_seen", bus.cop_rsp_valid, 1);
    chk("bp_b_rd", bus.cop_rsp_rd, 1);
    chk("bp_b_wdata", bus.cop_rsp_wdata, 32'hBBBB_BBBB);
    nxt();
    chk("bp_drained", bus.cop_rsp_valid, 0);
    chk("bp_empty", id_encoded, 0);

    // Pointer wrap: 7 back-to-back instructions
    echo = 1; ex_ready = 1; ex_status = 3'b000; ex_wen = 1; bus.cop_rsp_ready = 1;
    sent = 0; rcnt = 0;
    for (int c = 0; c < 100 && rcnt < 7; c++) begin
      if (ex_valid) chk("wrap_ex_rs1", ex_rs1, rs1_of(rcnt));
      if (bus.cop_rsp_valid) begin
        chk("wrap_rd", bus.cop_rsp_rd, rcnt + 3);
        chk("wrap_wdata", bus.cop_rsp_wdata, rs1_of(rcnt) ^ 32'hFFFF_0000);
        rcnt++;
      end
      if (sent < 7) begin
        bus.cpu_insn_req = 1; bus.cpu_insn_enc = enc_of(sent); bus.cpu_rs1 = rs1_of(sent);
        if (bus.cpu_insn_ack) sent++;
      end else begin
        bus.cpu_insn_req = 0;
      end
      nxt();
    end
    bus.cpu_insn_req = 0; echo = 0;
    chk("wrap_rsp_count", rcnt, 7);
    chk("wrap_sent_count", sent, 7);
    nxt();
    chk("wrap_empty", id_encoded, 0);

    // Slow execute with a stray ex_ready during RESP
    ex_ready = 0;
    bus.cpu_insn_req = 1; bus.cpu_insn_enc = 32'h0000_2800; bus.cpu_rs1 = 32'h77;
    nxt();
    bus.cpu_insn_req = 0;
    for (int n = 0; n < 5 && !ex_valid; n++) nxt();
    chk("slow_ex_seen", ex_valid, 1);
    for (int i = 0; i < 10; i++) begin
      chk("slow_ex_hold", ex_valid, 1);
      chk("slow_no_rsp", bus.cop_rsp_valid, 0);
      nxt();
    end
    ex_ready = 1; ex_status = 3'b111; ex_wen = 0; ex_wdata_r = 32'hFFFF_FFFF;
    bus.cop_rsp_ready = 0;
    nxt();
    chk("slow_valid", bus.cop_rsp_valid, 1);
    chk("slow_status", bus.cop_rsp_status, 3'b111);
    chk("slow_wen", bus.cop_rsp_wen, 0);
    chk("slow_wdata_zero", bus.cop_rsp_wdata, 0);
    chk("slow_rd", bus.cop_rsp_rd, 5);
    chk("slow_ex_drop", ex_valid, 0);
    ex_status = 3'b010; ex_wen = 1; ex_wdata_r = 32'h0000_1234;
    nxt();
    chk("stray_status", bus.cop_rsp_status, 3'b111);
    chk("stray_wen", bus.cop_rsp_wen, 0);
    chk("stray_wdata", bus.cop_rsp_wdata, 0);
    ex_ready = 0; bus.cop_rsp_ready = 1;
    nxt();
    chk("slow_done", bus.cop_rsp_valid, 0);
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.cop_rsp_valid || ex_valid) hits++;
      nxt();
    end
    chk("slow_single_rsp", hits, 0);

    // Reset in the middle of EXEC with two entries queued
    ex_ready = 0;
    bus.cpu_insn_req = 1; bus.cpu_insn_enc = 32'h0000_1000; bus.cpu_rs1 = 32'hA;
    nxt();
    bus.cpu_insn_enc = 32'h0000_1800; bus.cpu_rs1 = 32'hB;
    nxt();
    bus.cpu_insn_req = 0;
    chk("mrst_pre_ex", ex_valid, 1);
    chk("mrst_pre_full", bus.cpu_insn_ack, 0);
    g_reset = 1;
    nxt();
    chk("mrst_id_enc", id_encoded, 0);
    chk("mrst_ex_valid", ex_valid, 0);
    chk("mrst_valid", bus.cop_rsp_valid, 0);
    chk("mrst_ack", bus.cpu_insn_ack, 1);
    chk("mrst_ex_rs1", ex_rs1, 0);
    g_reset = 0; ex_ready = 1;
    hits = 0;
    for (int i = 0; i < 3; i++) begin
      nxt();
      if (bus.cop_rsp_valid || ex_valid) hits++;
    end
    chk("mrst_quiet", hits, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
